spi_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of `spi_master`. It accepts one SPI command at a time on a valid/ready interface and drives `spi_master`'s `wr_req`/`rd_req`/`wr_data`/bit-count inputs. It completes the four-phase req/ack handshake and returns captured read data plus a status flag on a valid/ready response interface. It also bounds every transaction with a timeout and optionally reflects data for LSB-first devices.

---
 rtl/spi_pkg.sv | 15 +
 rtl/bit_reflect.sv | 24 ++
 rtl/spi_cmd_seq.sv | 203 ++++++++++++++++++++
 tb/tb_spi_cmd_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer: state encoding and bit-count width.
package spi_pkg;

  localparam int unsigned NbitsW = 8;

  typedef logic [NbitsW-1:0] nbits_t;

  // Sequencer state encoding (kept as plain constants for legacy tooling)
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StRel  = 3'd2;
  localparam logic [2:0] StRsp  = 3'd3;
  localparam logic [2:0] StQuar = 3'd4;

endpackage

// File: rtl/bit_reflect.sv
// Reverses the low n_i bits of a word; bits at or above n_i read as zero.
module bit_reflect
  import spi_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] data_i,
  input  nbits_t           n_i,
  output logic [Width-1:0] data_o
);

  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1;

  // Out-of-range counts produce zero rather than indexing past the word
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if ((i < 32'(n_i)) && (32'(n_i) <= Width)) begin
        data_o[i] = data_i[IdxW'(32'(n_i) - 32'd1 - i)];
      end
    end
  end

endmodule

// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of spi_master: one command in flight, four-phase req/ack
// handshake, bounded wait for ack with a quarantine after abort, optional LSB-first reflect.
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_TIMEOUT    = 65535
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_wr_i,
  input  logic                    cmd_rd_i,
  input  logic                    cmd_lsb_first_i,
  input  logic [NbitsW-1:0]       cmd_nbits_i,
  input  logic [P_DATA_WIDTH-1:0] cmd_data_i,
  output logic                    wr_req_o,
  output logic                    rd_req_o,
  output logic [P_DATA_WIDTH-1:0] wr_data_o,
  output logic [NbitsW-1:0]       nb_mosi_o,
  output logic [NbitsW-1:0]       nb_miso_o,
  output logic [NbitsW-1:0]       nb_sclk_o,
  input  logic                    ack_i,
  input  logic [P_DATA_WIDTH-1:0] rd_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [P_DATA_WIDTH-1:0] rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);

  // Counter must reach P_TIMEOUT (quarantine end), hence the +2
  localparam int unsigned    CntW     = $clog2(P_TIMEOUT + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(P_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntQuar = CntW'(P_TIMEOUT);

  logic [2:0]              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic                    lsb_q, lsb_d;
  nbits_t                  nbits_q, nbits_d;
  logic                    wr_req_q, wr_req_d;
  logic                    rd_req_q, rd_req_d;
  logic [P_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [P_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;

  logic [P_DATA_WIDTH-1:0] wr_refl;
  logic [P_DATA_WIDTH-1:0] rd_refl;
  logic [P_DATA_WIDTH-1:0] nbits_mask;
  logic [P_DATA_WIDTH-1:0] rd_word;
  logic                    cmd_illegal;

  bit_reflect #(
    .Width (P_DATA_WIDTH)
  ) u_wr_reflect (
    .data_i (cmd_data_i),
    .n_i    (cmd_nbits_i),
    .data_o (wr_refl)
  );

  bit_reflect #(
    .Width (P_DATA_WIDTH)
  ) u_rd_reflect (
    .data_i (rd_data_i),
    .n_i    (nbits_q),
    .data_o (rd_refl)
  );

  // Mask of the low nbits bits of the latched command
  always_comb begin
    nbits_mask = '0;
    for (int unsigned i = 0; i < P_DATA_WIDTH; i++) begin
      nbits_mask[i] = (i < 32'(nbits_q));
    end
  end

  assign cmd_illegal = (!cmd_wr_i && !cmd_rd_i) || (cmd_nbits_i == '0) ||
                       (32'(cmd_nbits_i) > P_DATA_WIDTH);

  // Next state, latched command and response; outputs are derived from the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    lsb_d      = lsb_q;
    nbits_d    = nbits_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rd_word    = rd_q ? (lsb_q ? rd_refl : (rd_data_i & nbits_mask)) : '0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          wr_d       = cmd_wr_i;
          rd_d       = cmd_rd_i;
          lsb_d      = cmd_lsb_first_i;
          nbits_d    = cmd_nbits_i;
          wr_data_d  = cmd_lsb_first_i ? wr_refl : cmd_data_i;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = cmd_illegal;
          state_d    = cmd_illegal ? StRsp : StReq;
        end
      end
      StReq: begin
        if (ack_i) begin
          rsp_data_d = rd_word;
          state_d    = StRel;
        end else if (cnt_q == CntLast) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          cnt_d      = '0;
          state_d    = StQuar;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRel: begin
        if (!ack_i) begin
          state_d = StRsp;
        end
      end
      StQuar: begin
        // Held one cycle past P_TIMEOUT so the response trails the request drop by P_TIMEOUT+1
        if (cnt_q == CntQuar) begin
          state_d = StRsp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRsp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    wr_req_d    = (state_d == StReq) && wr_d;
    rd_req_d    = (state_d == StReq) && rd_d;
    rsp_valid_d = (state_d == StRsp);
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      lsb_q       <= 1'b0;
      nbits_q     <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      lsb_q       <= lsb_d;
      nbits_q     <= nbits_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign wr_req_o    = wr_req_q;
  assign rd_req_o    = rd_req_q;
  assign wr_data_o   = wr_data_q;
  assign nb_mosi_o   = nbits_q;
  assign nb_miso_o   = nbits_q;
  assign nb_sclk_o   = nbits_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Self-checking bench for spi_cmd_seq: per-cycle expectations from a transaction-level model.
module tb_spi_cmd_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic          cmd_rd = 1'b0;
  logic          cmd_lsb = 1'b0;
  logic [7:0]    cmd_nbits = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          wr_req, rd_req;
  logic [DW-1:0] wr_data;
  logic [7:0]    nb_mosi, nb_miso, nb_sclk;
  logic          ack = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  spi_cmd_seq #(
    .P_DATA_WIDTH (DW),
    .P_TIMEOUT    (TO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_wr_i        (cmd_wr),
    .cmd_rd_i        (cmd_rd),
    .cmd_lsb_first_i (cmd_lsb),
    .cmd_nbits_i     (cmd_nbits),
    .cmd_data_i      (cmd_data),
    .wr_req_o        (wr_req),
    .rd_req_o        (rd_req),
    .wr_data_o       (wr_data),
    .nb_mosi_o       (nb_mosi),
    .nb_miso_o       (nb_miso),
    .nb_sclk_o       (nb_sclk),
    .ack_i           (ack),
    .rd_data_i       (rd_data),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_err_o       (rsp_err),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Expected outputs for the current cycle
  bit            chk_en = 1'b0;
  bit            e_ready, e_busy, e_wr, e_rd, e_rspv, e_err;
  logic [DW-1:0] e_wd, e_rdata;
  logic [7:0]    e_nb;

  // Observations used by the literal checks
  logic [DW-1:0] obs_wd, obs_rd;
  logic          obs_err;
  bit            prev_req = 1'b0, prev_rspv = 1'b0;
  int            rise_cyc, drop_cyc, rspv_cyc, acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Compare process: outputs sampled mid-cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("wr_req", 32'(wr_req), 32'(e_wr));
      chk("rd_req", 32'(rd_req), 32'(e_rd));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
      chk("nb_mosi", 32'(nb_mosi), 32'(e_nb));
      chk("nb_miso", 32'(nb_miso), 32'(e_nb));
      chk("nb_sclk", 32'(nb_sclk), 32'(e_nb));
      if (e_wr || e_rd) chk("wr_data", wr_data, e_wd);
      if (e_rspv) begin
        chk("rsp_data", rsp_data, e_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      if (wr_req || rd_req) obs_wd = wr_data;
      if (rsp_valid) begin
        obs_rd  = rsp_data;
        obs_err = rsp_err;
      end
      if ((wr_req || rd_req) && !prev_req) rise_cyc = cyc_n;
      if (!(wr_req || rd_req) && prev_req) drop_cyc = cyc_n;
      if (rsp_valid && !prev_rspv) rspv_cyc = cyc_n;
      prev_req  = wr_req || rd_req;
      prev_rspv = rsp_valid;
    end
  end

  function automatic logic [31:0] m_refl(input logic [31:0] x, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = (r << 1) | ((x >> i) & 32'd1);
    return r;
  endfunction

  function automatic logic [31:0] m_mask(input int n);
    logic [63:0] m = (64'd1 << n) - 64'd1;
    return (n >= 32) ? 32'hFFFF_FFFF : m[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_ready = 1; e_busy = 0; e_wr = 0; e_rd = 0; e_rspv = 0;
  endtask

  task automatic set_req(input bit wr, input bit rd, input logic [31:0] wd);
    e_ready = 0; e_busy = 1; e_wr = wr; e_rd = rd; e_rspv = 0; e_wd = wd;
  endtask

  task automatic set_wait();
    e_ready = 0; e_busy = 1; e_wr = 0; e_rd = 0; e_rspv = 0;
  endtask

  task automatic set_rsp(input logic [31:0] d, input bit err);
    e_ready = 0; e_busy = 1; e_wr = 0; e_rd = 0; e_rspv = 1; e_rdata = d; e_err = err;
  endtask

  // Inputs the DUT must ignore while it is not in the matching phase
  task automatic noise(input bit junk, input bit allow_ready);
    cmd_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_rd    = 1'($urandom);
    cmd_lsb   = 1'($urandom);
    cmd_nbits = 8'($urandom_range(0, 40));
    cmd_data  = $urandom;
    if (junk) rd_data = $urandom;
    if (allow_ready) rsp_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // One command from accept to response consumed; starts and ends in an idle cycle
  task automatic run_cmd(input bit wr, input bit rd, input bit lsb, input int nbits,
                         input logic [31:0] data, input logic [31:0] stub, input int ack_k,
                         input int ack_h, input int rdy_d, input bit junk);
    bit          legal, timed_out;
    logic [31:0] wd, exp_rd;
    legal = (wr || rd) && (nbits >= 1) && (nbits <= 32);
    wd    = lsb ? m_refl(data, nbits) : data;
    set_idle();
    rsp_ready = 0;
    cmd_valid = 1; cmd_wr = wr; cmd_rd = rd; cmd_lsb = lsb;
    cmd_nbits = 8'(nbits); cmd_data = data;
    acc_cyc = cyc_n;
    tick();
    e_nb = 8'(nbits);
    if (!legal) begin
      set_rsp(32'd0, 1'b1);
    end else begin
      timed_out = 1;
      for (int i = 0; i < int'(TO); i++) begin
        set_req(wr, rd, wd);
        noise(junk, 1'b1);
        ack     = (i >= ack_k);
        rd_data = stub;
        tick();
        if (i >= ack_k) begin
          timed_out = 0;
          break;
        end
      end
      if (!timed_out) begin
        for (int j = 1; j <= ack_h; j++) begin
          set_wait();
          noise(junk, 1'b1);
          ack = (j < ack_h);
          tick();
        end
        exp_rd = !rd ? 32'd0 : (lsb ? m_refl(stub, nbits) : (stub & m_mask(nbits)));
        set_rsp(exp_rd, 1'b0);
      end else begin
        ack = 0;
        for (int j = 0; j <= int'(TO); j++) begin
          set_wait();
          noise(junk, 1'b1);
          tick();
        end
        set_rsp(32'd0, 1'b1);
      end
    end
    ack = 0;
    for (int j = 0; j <= rdy_d; j++) begin
      noise(junk, 1'b0);
      rsp_ready = (j == rdy_d);
      tick();
    end
    rsp_ready = 0;
    cmd_valid = 0;
    set_idle();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      set_idle();
      cmd_valid = 0;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    set_idle();
    e_nb = '0;
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    tick();
    rst_n = 1;
    idle_cycles(2);

    // Write 0xA5, 8 bits, MSB first, ack 20 cycles after wr_req rises
    run_cmd(1, 0, 0, 8, 32'hA5, 32'h0, 20, 1, 0, 0);
    chk("lit_wr_data", obs_wd, 32'h0000_00A5);
    chk("lit_wr_req_len", 32'(drop_cyc - rise_cyc), 32'd21);
    chk("lit_wr_rsp_lat", 32'(rspv_cyc - acc_cyc), 32'd23);
    chk("lit_wr_rsp_data", obs_rd, 32'h0);
    chk("lit_wr_rsp_err", 32'(obs_err), 32'd0);
    idle_cycles(2);

    // Read 12 bits LSB first
    run_cmd(0, 1, 1, 12, 32'h0, 32'h0000_0C35, 3, 2, 1, 0);
    chk("lit_rd_lsb", obs_rd, 32'h0000_0AC3);
    chk("lit_rd_err", 32'(obs_err), 32'd0);
    idle_cycles(1);

    // Illegal commands answer one cycle after accept
    run_cmd(0, 0, 0, 8, 32'h12, 32'h0, 0, 1, 0, 0);
    chk("lit_ill_noop_lat", 32'(rspv_cyc - acc_cyc), 32'd1);
    chk("lit_ill_noop_err", 32'(obs_err), 32'd1);
    run_cmd(1, 1, 0, 0, 32'h34, 32'h0, 0, 1, 2, 0);
    chk("lit_ill_n0_lat", 32'(rspv_cyc - acc_cyc), 32'd1);
    run_cmd(1, 0, 1, 33, 32'h56, 32'h0, 0, 1, 1, 0);
    chk("lit_ill_n33_lat", 32'(rspv_cyc - acc_cyc), 32'd1);
    chk("lit_ill_n33_err", 32'(obs_err), 32'd1);
    idle_cycles(1);

    // Timeout with ack held low
    run_cmd(0, 1, 0, 16, 32'h0, 32'hFFFF_FFFF, 1000, 1, 0, 0);
    chk("lit_to_req_len", 32'(drop_cyc - rise_cyc), 32'(TO));
    chk("lit_to_rsp_gap", 32'(rspv_cyc - drop_cyc), 32'(TO + 1));
    chk("lit_to_err", 32'(obs_err), 32'd1);
    chk("lit_to_data", obs_rd, 32'h0);

    // Ack already high on REQ entry, then back-to-back with a stalled response
    run_cmd(1, 1, 0, 32, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 5, 1);
    chk("lit_full_word", obs_rd, 32'h1234_5678);
    run_cmd(1, 1, 1, 4, 32'h0000_000B, 32'hFFFF_FFF1, 2, 1, 5, 1);
    chk("lit_rd4_lsb", obs_rd, 32'h0000_0008);

    // Reset for one cycle while in REQ
    set_idle();
    cmd_valid = 1; cmd_wr = 1; cmd_rd = 0; cmd_lsb = 0; cmd_nbits = 8'd8; cmd_data = 32'h77;
    tick();
    e_nb = 8'd8;
    cmd_valid = 0;
    set_req(1, 0, 32'h77);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    e_nb = '0;
    idle_cycles(3);

    // Randomized commands
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: nb = 0;
          1: nb = 33;
          default: nb = 255;
        endcase
      end else begin
        nb = int'($urandom_range(1, 32));
      end
      run_cmd(1'($urandom), 1'($urandom), 1'($urandom), nb, $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? int'(TO) + 5 : int'($urandom_range(0, 9)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 4)), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
